xadc_temp_sampler: RTL

Periodic XADC on-die temperature sampler sitting directly upstream of the UART temperature transmitter. On a fixed sample timer it reads the XADC temperature status register over the DRP and averages 2^AVG_LOG2 readings. It converts the average to signed hundredths of a degree Celsius and hands the result to the transmitter with a one-cycle `start` pulse, gated by the transmitter's `busy`.

---
 rtl/xadc_temp_sampler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/xadc_temp_sampler.sv
// Periodic XADC temperature sampler: DRP reads on a timer, 2^AVG_LOG2 averaging,
// conversion to signed hundredths of a degree, handshake to the UART transmitter.
module xadc_temp_sampler #(
   parameter int unsigned SAMPLE_PERIOD = 1_000_000,
   parameter int unsigned AVG_LOG2      = 4,
   parameter int unsigned DRDY_TIMEOUT  = 64,
   parameter logic [6:0]  TEMP_ADDR     = 7'h00
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               drp_den,
   output logic               drp_dwe,
   output logic [6:0]         drp_daddr,
   input  logic [15:0]        drp_do,
   input  logic               drp_drdy,
   input  logic               tx_busy,
   output logic               start,
   output logic signed [31:0] temp_x100,
   output logic               timeout_err
);

   localparam int unsigned TW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned WCW  = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
   localparam int unsigned AW   = 12 + AVG_LOG2;
   localparam int unsigned NW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned NMAX = (1 << AVG_LOG2) - 1;

   localparam logic [TW-1:0]  TICK_VAL = TW'(SAMPLE_PERIOD - 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(DRDY_TIMEOUT - 1);
   localparam logic [NW-1:0]  N_LAST   = NW'(NMAX);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StAcc, StConv} state_e;

   state_e         state_q;
   logic [TW-1:0]  timer_q;
   logic [WCW-1:0] wait_cnt_q;
   logic [11:0]    code_q;
   logic [AW-1:0]  acc_q;
   logic [NW-1:0]  n_q;
   logic           pending_q;

   logic                tick;
   logic                pend_set;
   logic [11:0]         avg;
   logic [27:0]         prod;
   logic [15:0]         scaled;
   logic signed [31:0]  conv_val;
   logic                unused_nibble;

   assign drp_dwe       = 1'b0;
   assign drp_daddr     = TEMP_ADDR;
   assign unused_nibble = ^drp_do[3:0];

   assign tick = (timer_q == TICK_VAL);

   // avg * 50398 / 4096 is avg * 503.98 / 4096 * 100, i.e. Kelvin x100.
   assign avg      = 12'(acc_q >> AVG_LOG2);
   assign prod     = 28'(avg) * 28'd50398;
   assign scaled   = 16'(prod >> 12);
   assign conv_val = $signed({16'd0, scaled}) - 32'sd27315;

   // A conversion finishing this cycle can publish straight away.
   assign pend_set = pending_q | (state_q == StConv);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else if (tick) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         drp_den     <= 1'b0;
         timeout_err <= 1'b0;
         start       <= 1'b0;
         temp_x100   <= '0;
         wait_cnt_q  <= '0;
         code_q      <= '0;
         acc_q       <= '0;
         n_q         <= '0;
         pending_q   <= 1'b0;
      end else begin
         drp_den     <= 1'b0;
         timeout_err <= 1'b0;

         if (pend_set && !tx_busy && !start) begin
            start     <= 1'b1;
            pending_q <= 1'b0;
         end else begin
            start     <= 1'b0;
            pending_q <= pend_set;
         end

         unique case (state_q)
            StIdle: begin
               if (tick) begin
                  state_q <= StReq;
                  drp_den <= 1'b1;
               end
            end
            StReq: begin
               wait_cnt_q <= '0;
               state_q    <= StWait;
            end
            StWait: begin
               if (drp_drdy) begin
                  code_q  <= drp_do[15:4];
                  state_q <= StAcc;
               end else if (wait_cnt_q == WAIT_MAX) begin
                  timeout_err <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StAcc: begin
               acc_q <= acc_q + AW'(code_q);
               if (n_q == N_LAST) begin
                  n_q     <= '0;
                  state_q <= StConv;
               end else begin
                  n_q     <= n_q + 1'b1;
                  state_q <= StIdle;
               end
            end
            StConv: begin
               temp_x100 <= conv_val;
               acc_q     <= '0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
